// File: rtl/array_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : array_scan_reader
// Purpose  : Walks a contiguous, wrapping index range of a synchronous-read
//            register array. Each word goes out on a valid/ready stream,
//            tagged with its index and a last flag.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            start, start_index,
//            count              - scan command (accepted only when idle)
//            busy, done         - scan status (done is a one-cycle pulse)
//            rd_en, rd_addr,
//            rd_data            - array read port (1-cycle read latency)
//            out_valid, out_ready,
//            out_data, out_index,
//            out_last           - output word stream
// Options  : define ARRAY_SCAN_READER_TRACE_EN to print every output
//            handshake in simulation as "ReadVal[<index>] = <data hex>".
// Revision : 1.0 - initial release
// ============================================================================
module array_scan_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_index,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur_idx;
  logic [ADDR_W:0]     r_remaining;

  // Read issued last cycle; its data is on rd_data this cycle.
  logic                r_pend;
  logic [ADDR_W-1:0]   r_pend_idx;
  logic                r_pend_last;

  // Two-entry output FIFO.
  logic [DATA_W-1:0]   r_fifo_data [2];
  logic [ADDR_W-1:0]   r_fifo_idx  [2];
  logic                r_fifo_last [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_occ;

  logic [1:0]          w_avail;
  logic                w_fifo_nonempty;
  logic                w_pop;
  logic                w_pop_fifo;
  logic                w_store;
  logic [1:0]          w_occ_nxt;
  logic [ADDR_W-1:0]   w_idx_inc;
  logic                w_last_issue;

  // The landing read word counts as part of the FIFO. When the stored
  // part is empty it is presented straight from rd_data, so the first word
  // shows up in the capture cycle. If nobody takes it, it is stored and
  // re-presented from the FIFO with identical fields.
  assign w_avail         = r_occ + {1'b0, r_pend};
  assign w_fifo_nonempty = (r_occ != 2'd0);
  assign out_valid       = (w_avail != 2'd0);
  assign w_pop           = out_valid && out_ready;
  assign w_pop_fifo      = w_pop && w_fifo_nonempty;
  assign w_store         = r_pend && !(w_pop && !w_fifo_nonempty);
  assign w_occ_nxt       = w_avail - {1'b0, w_pop};

  always_comb begin
    out_data  = r_fifo_data[r_rd_ptr];
    out_index = r_fifo_idx[r_rd_ptr];
    out_last  = r_fifo_last[r_rd_ptr];
    if (!w_fifo_nonempty && r_pend) begin
      out_data  = rd_data;
      out_index = r_pend_idx;
      out_last  = r_pend_last;
    end
  end

  // One credit is reserved for the read in flight, so whatever lands next
  // cycle always has a slot even if out_ready stays low.
  assign rd_en        = (r_state == S_RUN) && (r_remaining != '0) && (w_avail < 2'd2);
  assign rd_addr      = r_cur_idx;
  assign w_last_issue = (r_remaining == {{ADDR_W{1'b0}}, 1'b1});

  // Explicit wrap so DEPTH need not be a power of two.
  assign w_idx_inc = (r_cur_idx == ADDR_W'(DEPTH - 1)) ? '0 : r_cur_idx + 1'b1;

  assign busy = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cur_idx   <= '0;
      r_remaining <= '0;
      r_pend      <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_last <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_occ       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_idx[i]  <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_store) begin
        r_fifo_data[r_wr_ptr] <= rd_data;
        r_fifo_idx[r_wr_ptr]  <= r_pend_idx;
        r_fifo_last[r_wr_ptr] <= r_pend_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop_fifo) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ  <= w_occ_nxt;
      r_pend <= rd_en;

      if (rd_en) begin
        r_pend_idx  <= r_cur_idx;
        r_pend_last <= w_last_issue;
        r_cur_idx   <= w_idx_inc;
        r_remaining <= r_remaining - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur_idx   <= start_index;
            r_remaining <= count;
            r_state     <= (count != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (rd_en && w_last_issue) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // No reads are issued here, so an empty next occupancy means the
          // last word has been handed off.
          if (w_occ_nxt == 2'd0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ARRAY_SCAN_READER_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_pop) begin
      $display("ReadVal[%0d] = %h", out_index, out_data);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_array_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_scan_reader
// Purpose  : Self-checking bench for array_scan_reader. Models a 4x32
//            synchronous-read array, queues expected words when a scan is
//            started and compares them against the output handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_scan_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  start_index;
  logic [2:0]  count;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_index;
  logic        out_last;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] arr [4];
  logic [34:0] sb [$];          // {last, index, data}
  logic        h_pend = 1'b0;
  logic [35:0] h_word = '0;

  array_scan_reader #(.DATA_W(32), .ADDR_W(2), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_index (start_index),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read array: data valid exactly one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= arr[rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor: scoreboard compare on every handshake, plus stability
  // of a stalled word.
  always @(negedge clk) begin
    if (reset) begin
      h_pend = 1'b0;
    end else begin
      if (h_pend) check("hold_stable", {out_valid, out_last, out_index, out_data}, h_word);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_word", {1'b1, out_last, out_index, out_data}, 0);
        else check("word", {out_last, out_index, out_data}, sb.pop_front());
      end
      h_pend = out_valid && !out_ready;
      h_word = {out_valid, out_last, out_index, out_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one scan. Cycle n is the n-th cycle after the one where start is
  // high. out_ready is low for cycles 1..ready_low; a second start pulse is
  // driven in cycle restart_at (0 = none).
  task automatic run_scan(input logic [1:0] sidx, input logic [2:0] cnt,
                          input int ready_low, input int restart_at,
                          output int lat_done, output int first_valid,
                          output int n_valid, output int n_rden,
                          output int n_rden_stall, output bit saw_busy,
                          output logic [31:0] stall_data);
    lat_done = 0; first_valid = 0; n_valid = 0; n_rden = 0;
    n_rden_stall = 0; saw_busy = 1'b0; stall_data = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      logic [1:0] ix;
      logic       lst;
      ix  = 2'((int'(sidx) + i) % 4);
      lst = (i == int'(cnt) - 1);
      sb.push_back({lst, ix, arr[ix]});
    end
    @(posedge clk); #1;
    start = 1'b1; start_index = sidx; count = cnt; out_ready = (ready_low == 0);
    for (int n = 1; n <= 40 && lat_done == 0; n++) begin
      @(posedge clk); #1;
      start = (n == restart_at);
      if (n == restart_at) begin start_index = 2'd2; count = 3'd1; end
      out_ready = (n > ready_low);
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (rd_en) n_rden++;
      if (rd_en && n <= ready_low) n_rden_stall++;
      if (n == ready_low) stall_data = out_data;
      if (out_valid) begin
        n_valid++;
        if (first_valid == 0) first_valid = n;
      end
      if (done) begin
        lat_done = n;
        check("busy_low_in_done", busy, 0);
      end
    end
    start = 1'b0;
    if (lat_done == 0) check("scan_timeout", lat_done, 1);
    check("sb_drained", sb.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
  endtask

  initial begin
    int lat, fv, nv, nr, nst;
    bit sbusy;
    logic [31:0] sd;

    arr[0] = 32'h1; arr[1] = 32'h2; arr[2] = 32'h3; arr[3] = 32'h123;
    reset = 1'b1; start = 1'b0; start_index = '0; count = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_outs", {done, rd_en, out_valid, out_last, rd_addr, out_index, out_data}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Single word at the top index.
    run_scan(2'd3, 3'd1, 0, 0, lat, fv, nv, nr, nst, sbusy, sd);
    check("t1_done_lat", lat, 3);
    check("t1_first_valid", fv, 2);
    check("t1_n_valid", nv, 1);
    check("t1_n_rden", nr, 1);
    check("t1_busy", sbusy, 1);

    // Full wrapping scan at full rate.
    run_scan(2'd2, 3'd4, 0, 0, lat, fv, nv, nr, nst, sbusy, sd);
    check("t2_done_lat", lat, 6);
    check("t2_first_valid", fv, 2);
    check("t2_n_valid", nv, 4);
    check("t2_n_rden", nr, 4);

    // Backpressure: consumer stalls for 5 cycles.
    run_scan(2'd0, 3'd4, 5, 0, lat, fv, nv, nr, nst, sbusy, sd);
    check("t3_rden_in_stall", nst, 2);
    check("t3_stall_data", sd, 32'h1);
    check("t3_n_rden", nr, 4);
    check("t3_done_lat", lat, 10);

    // Empty scan.
    run_scan(2'd1, 3'd0, 0, 0, lat, fv, nv, nr, nst, sbusy, sd);
    check("t4_done_lat", lat, 1);
    check("t4_n_valid", nv, 0);
    check("t4_n_rden", nr, 0);
    check("t4_busy", sbusy, 0);

    // Reset in the middle of a scan after two words.
    sb.push_back({1'b0, 2'd0, 32'h1});
    sb.push_back({1'b0, 2'd1, 32'h2});
    @(posedge clk); #1;
    start = 1'b1; start_index = 2'd0; count = 3'd4; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    #1 reset = 1'b1;
    check("t5_two_words", sb.size(), 0);
    @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_outs", {done, rd_en, out_valid, out_last, rd_addr, out_index, out_data}, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_done", {done, out_valid}, 0);
    end
    run_scan(2'd1, 3'd2, 0, 0, lat, fv, nv, nr, nst, sbusy, sd);
    check("t5_done_lat", lat, 4);
    check("t5_n_valid", nv, 2);

    // Start pulsed while busy must be ignored.
    run_scan(2'd1, 3'd4, 0, 2, lat, fv, nv, nr, nst, sbusy, sd);
    check("t6_done_lat", lat, 6);
    check("t6_n_valid", nv, 4);
    check("t6_n_rden", nr, 4);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/array_scan_reader.md
Name: array_scan_reader

Overview:
- Read-side counterpart to the FSM-driven register-array writers produced by the VSharp flow.
- On a start command it walks a contiguous index range of a synchronous-read register array.
- It streams each word out on a valid/ready interface, tagged with its index and a last flag.
- It sits between a generated array (e.g. a 4x32 test array) and any downstream consumer or checker.

Parameters:
- DATA_W, 32, width of an array word.
- ADDR_W, 2, index width.
- DEPTH, 4, number of array entries; indices wrap modulo DEPTH; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  clock, rising-edge active.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- start_index  in  ADDR_W  first index to read.
- count  in  ADDR_W+1  number of words to read, 0..DEPTH.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the scan is complete.
- rd_en  out  1  array read strobe.
- rd_addr  out  ADDR_W  array read index.
- rd_data  in  DATA_W  array read data, valid exactly 1 cycle after rd_en.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  DATA_W  word read.
- out_index  out  ADDR_W  index the word came from.
- out_last  out  1  marks the final word of the scan.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state = IDLE; busy, done, rd_en, out_valid, out_last = 0; rd_addr, out_data, out_index = 0.
  - Output FIFO is emptied.
  - In-flight reads are discarded; no done pulse is produced for an aborted scan.
- States:
  - IDLE: start=1 latches start_index as cur_idx and count as remaining. Next state is RUN if count ≠ 0, else DONE. start is ignored in every other state.
  - RUN: issues reads. Moves to FLUSH in the cycle after the read that makes remaining 0 is issued.
  - FLUSH: no new reads. Moves to DONE when the FIFO is empty and no read is outstanding.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy = (state==RUN || state==FLUSH).
- Read issue (RUN only):
  - rd_en=1 when FIFO occupancy + outstanding reads < 2.
  - rd_addr = cur_idx.
  - On issue: cur_idx = (cur_idx+1) mod DEPTH and remaining decrements. Wrap is explicit, so DEPTH need not be a power of two.
  - rd_en is combinational from registered state; at most one read is outstanding.
- Capture:
  - rd_data is pushed into a 2-entry FIFO the cycle after rd_en, with its index.
  - last flag = 1 if it was the final issued read.
  - Credit accounting guarantees the FIFO never overflows, even with out_ready held low.
- Output:
  - out_valid = FIFO not empty; out_data, out_index and out_last show the FIFO head.
  - Head pops on out_valid && out_ready.
  - Once asserted, out_valid and the head fields stay stable until the word is accepted.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- Latency:
  - With out_ready=1, the first word is valid 2 cycles after start.
  - Throughput is 1 word/cycle sustained.
  - done asserts 1 cycle after the last word is accepted.
- count > DEPTH is illegal and produces undefined output order; the bench must not drive it.

Optional Feature:
- Macro: ARRAY_SCAN_READER_TRACE_EN.
- Defined: on every output handshake, a simulation-only $display prints "ReadVal[<index>] = <data hex>".
- Not defined: no display statements are compiled.
- Synthesized logic is identical either way.

Test Plan:
- Array preload {0:0x1, 1:0x2, 2:0x3, 3:0x123}; start_index=3, count=1, out_ready=1 -> one word 0x123, index 3, last=1; done pulses 3 cycles after start.
- Same preload; start_index=2, count=4, out_ready=1 -> indices 2,3,0,1 on consecutive cycles with data 0x3,0x123,0x1,0x2; last only on index 1.
- start_index=0, count=4, out_ready low for 5 cycles after start -> rd_en stops after 2 reads; out_data stays 0x1 stable; no loss or duplication after out_ready rises.
- count=0 -> no rd_en, no out_valid; done pulses 1 cycle after start; busy never asserts.
- Reset asserted in RUN after 2 words -> next cycle all outputs 0, state IDLE, no done; a new start with count=2 then operates normally.
- start pulsed again while busy with start_index=1 -> ignored; the original scan completes unchanged.
